inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: fetch address width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction and bus data width.
REQ-003 SHALL have parameter ARPROT_VAL, default 3'b100: constant driven on arprot (instruction access).
REQ-004 SHALL have port clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port pc_i  in  ADDR_W  current fetch address from the PC register.
REQ-007 SHALL have port fetch_en_i  in  1  fetch enable, 0 while the core is held in reset.
REQ-008 SHALL have port stall_i  in  6  pipeline stall vector, bit 0 = PC stage held.
REQ-009 SHALL have port flush_i  in  1  pipeline flush (exception or eret redirect).
REQ-010 SHALL have ports araddr (out, ADDR_W), arprot (out, 3), arvalid (out, 1), arready (in, 1): AXI-Lite read address channel.
REQ-011 SHALL have ports rdata (in, DATA_W), rresp (in, 2), rvalid (in, 1), rready (out, 1): AXI-Lite read data channel.
REQ-012 SHALL have port inst_o  out  DATA_W  fetched instruction to IF/ID.
REQ-013 SHALL have port inst_valid_o  out  1  inst_o holds the instruction for the current pc_i.
REQ-014 SHALL have port stallreq_o  out  1  fetch-stage stall request to the pipeline controller.
REQ-015 SHALL have ports exc_adel_o and exc_buserr_o  out  1 each  misaligned-fetch and bus-error flags, valid with inst_valid_o.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA, DONE, DISCARD.
REQ-017 IDLE: if fetch_en_i=1 and flush_i=0, SHALL latch pc_i into araddr, then:
- pc_i[1:0]!=0 -> DONE, inst_o=0, exc_adel_o=1, no bus transaction.
- otherwise -> ADDR.
REQ-018 ADDR: arvalid=1 with araddr stable. On arready=1 -> DATA. arvalid SHALL NOT drop before the handshake, including under flush.
REQ-019 DATA: rready=1. On rvalid=1 -> DONE; SHALL capture inst_o=rdata when rresp=2'b00, else inst_o=0 and exc_buserr_o=1.
REQ-020 DONE: inst_valid_o=1.
- stall_i[0]=1 -> stay in DONE, holding inst_o and flags.
- stall_i[0]=0 -> IDLE; inst_valid_o and flags clear on that edge.
REQ-021 stallreq_o SHALL be 1 in ADDR, DATA and DISCARD, and in IDLE when fetch_en_i=1; 0 otherwise. It is combinational from state and fetch_en_i.
REQ-022 Flush in IDLE or DONE SHALL go to IDLE and clear inst_valid_o and flags.
REQ-023 Flush in ADDR SHALL set a discard flag, keep arvalid until arready, then enter DISCARD.
REQ-024 Flush in DATA SHALL go to DISCARD, or to IDLE if rvalid=1 in the same cycle. Flush has priority over the rvalid capture; the data is dropped.
REQ-025 DISCARD: rready=1; on rvalid=1 SHALL drop the data and go to IDLE; flush_i is ignored here.
REQ-026 SHALL keep at most one outstanding read; arvalid and rready never assert in the same state except under REQ-023.
REQ-027 fetch_en_i=0 in IDLE SHALL hold IDLE with stallreq_o=0 and inst_valid_o=0.
REQ-028 Minimum fetch latency SHALL be 4 cycles (IDLE, ADDR, DATA, DONE) with zero-wait arready and rvalid.

Reset
REQ-029 On rst=1 SHALL set state=IDLE, araddr=0, arvalid=0, rready=0, inst_o=0, inst_valid_o=0, exc flags=0 and discard flag=0.
REQ-030 Reset mid-transaction SHALL drop arvalid and rready on the next edge regardless of the handshake.

Structure
REQ-031 The shared header SHALL hold the FSM state encoding, the RESP_OKAY constant, the ARPROT instruction constant and the ADEL/bus-error exception codes.
REQ-032 SHALL be a single module with no sub-modules; one registered FSM plus a combinational output decode.

Verification
REQ-033 pc_i=0xBFC00000, arready and rvalid zero-wait, rdata=0x24080001 -> araddr=0xBFC00000, inst_o=0x24080001, inst_valid_o=1 on cycle 4 after leaving reset, stallreq_o=1 cycles 1-3.
REQ-034 arready delayed 3 cycles, rvalid delayed 2 cycles -> arvalid and araddr held stable throughout, stallreq_o=1 until DONE.
REQ-035 Flush in ADDR with arready=0, then arready=1 after 2 cycles, rvalid=1 with rdata=0xDEADBEEF -> data dropped, inst_valid_o stays 0, new fetch from the redirected pc_i.
REQ-036 pc_i=0xBFC00002 -> no arvalid, exc_adel_o=1, inst_o=0 in DONE.
REQ-037 rresp=2'b10 -> exc_buserr_o=1, inst_o=0.
REQ-038 stall_i[0]=1 for 5 cycles in DONE -> inst_o held, no new arvalid; rst=1 in DATA -> rready=0 next cycle, state IDLE.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// inst_fetch_ctrl_pkg -- shared types and constants for the instruction fetch
// Revision: 1.0
// ============================================================================
package inst_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_DONE    = 3'd3,
        S_DISCARD = 3'd4
    } fetch_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [2:0] ARPROT_INST = 3'b100;

    // MIPS-style cause codes for the fetch-side exceptions
    typedef logic [4:0] exc_code_t;
    localparam exc_code_t EXC_NONE   = 5'h00;
    localparam exc_code_t EXC_ADEL   = 5'h04;
    localparam exc_code_t EXC_BUSERR = 5'h06;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// inst_fetch_ctrl -- single-outstanding AXI-Lite instruction fetch controller
// Revision: 1.0
// ============================================================================
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter logic [2:0] ARPROT_VAL = ARPROT_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_en_i,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stallreq_o,
    output logic              exc_adel_o,
    output logic              exc_buserr_o
);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_nx;
    logic [DATA_W-1:0] inst_word, inst_word_nx;
    exc_code_t         exc_code, exc_code_nx;
    logic              discard, discard_nx;

    // Only the PC-stage hold bit matters to fetch
    logic unused_stall;
    assign unused_stall = ^stall_i[5:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fetch_addr <= '0;
            inst_word  <= '0;
            exc_code   <= EXC_NONE;
            discard    <= 1'b0;
        end else begin
            state      <= state_nx;
            fetch_addr <= fetch_addr_nx;
            inst_word  <= inst_word_nx;
            exc_code   <= exc_code_nx;
            discard    <= discard_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        fetch_addr_nx = fetch_addr;
        inst_word_nx  = inst_word;
        exc_code_nx   = exc_code;
        discard_nx    = discard;
        case (state)
            S_IDLE: begin
                inst_word_nx = '0;
                exc_code_nx  = EXC_NONE;
                if (fetch_en_i && !flush_i) begin
                    fetch_addr_nx = pc_i;
                    if (pc_i[1:0] != 2'b00) begin
                        exc_code_nx = EXC_ADEL;
                        state_nx    = S_DONE;
                    end else begin
                        state_nx = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                // A flush cannot retract arvalid; remember it and drain the read
                if (arready) begin
                    state_nx   = (discard || flush_i) ? S_DISCARD : S_DATA;
                    discard_nx = 1'b0;
                end else if (flush_i) begin
                    discard_nx = 1'b1;
                end
            end
            S_DATA: begin
                if (flush_i) begin
                    state_nx = rvalid ? S_IDLE : S_DISCARD;
                end else if (rvalid) begin
                    state_nx = S_DONE;
                    if (rresp == RESP_OKAY) begin
                        inst_word_nx = rdata;
                    end else begin
                        inst_word_nx = '0;
                        exc_code_nx  = EXC_BUSERR;
                    end
                end
            end
            S_DONE: begin
                if (flush_i || !stall_i[0]) begin
                    state_nx     = S_IDLE;
                    inst_word_nx = '0;
                    exc_code_nx  = EXC_NONE;
                end
            end
            S_DISCARD: begin
                if (rvalid) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign araddr       = fetch_addr;
    assign arprot       = ARPROT_VAL;
    assign arvalid      = (state == S_ADDR);
    assign rready       = (state == S_DATA) || (state == S_DISCARD);
    assign inst_o       = inst_word;
    assign inst_valid_o = (state == S_DONE);
    assign exc_adel_o   = (exc_code == EXC_ADEL);
    assign exc_buserr_o = (exc_code == EXC_BUSERR);
    assign stallreq_o   = (state == S_ADDR) || (state == S_DATA) ||
                          (state == S_DISCARD) || ((state == S_IDLE) && fetch_en_i);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_ctrl -- directed and randomized fetch transactions vs. a model
// Revision: 1.0
// ============================================================================
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        fetch_en_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stallreq_o;
    logic        exc_adel_o;
    logic        exc_buserr_o;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .ARPROT_VAL(3'b100)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .fetch_en_i(fetch_en_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst_o(inst_o), .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o),
        .exc_adel_o(exc_adel_o), .exc_buserr_o(exc_buserr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete fetch as seen from the core. The slave answers after the
    // requested wait counts; the expected word, flags and latency come from
    // the transaction rules alone.
    task automatic run_fetch(input logic [31:0] pc, input int ar_wait, input int r_wait,
                             input logic [31:0] data, input logic [1:0] resp,
                             input int stall_n, input bit flush_done);
        int cyc, arw, rw, exp_lat;
        bit done, saw_ar, mis;
        logic [31:0] exp_inst;
        logic [31:0] noise;
        mis      = (pc[1:0] != 2'b00);
        exp_inst = mis ? 32'h0 : ((resp == 2'b00) ? data : 32'h0);
        exp_lat  = mis ? 2 : 4 + ar_wait + r_wait;
        cyc = 0; arw = 0; rw = 0; done = 0; saw_ar = 0;
        pc_i = pc; fetch_en_i = 1'b1; flush_i = 1'b0; stall_i = 6'h0;
        while (!done && cyc < 64) begin
            arready = arvalid && (arw >= ar_wait);
            rvalid  = rready && (rw >= r_wait);
            noise   = $urandom;
            rdata   = rvalid ? data : noise;
            rresp   = rvalid ? resp : 2'($urandom);
            #1;
            if (inst_valid_o) begin
                done = 1;
            end else begin
                check("stallreq_busy", stallreq_o, 1);
                check("one_channel", arvalid & rready, 0);
                if (arvalid) begin
                    check("araddr_stable", araddr, pc);
                    saw_ar = 1;
                    arw++;
                end
                if (rready) rw++;
                cyc++;
                tick;
            end
        end
        arready = 1'b0; rvalid = 1'b0;
        check("latency", cyc + 1, exp_lat);
        check("inst_valid", inst_valid_o, 1);
        check("inst", inst_o, exp_inst);
        check("exc_adel", exc_adel_o, mis);
        check("exc_buserr", exc_buserr_o, !mis && (resp != 2'b00));
        check("bus_used", saw_ar, !mis);
        check("araddr_latched", araddr, pc);
        check("stallreq_done", stallreq_o, 0);
        check("arprot", arprot, 3'b100);
        for (int i = 0; i < stall_n; i++) begin
            stall_i = {5'($urandom), 1'b1};
            tick;
            check("hold_valid", inst_valid_o, 1);
            check("hold_inst", inst_o, exp_inst);
            check("hold_adel", exc_adel_o, mis);
            check("hold_no_ar", arvalid, 0);
        end
        // Flush must override a held stall
        stall_i    = {5'($urandom), flush_done};
        flush_i    = flush_done;
        fetch_en_i = 1'b0;
        tick;
        flush_i = 1'b0;
        check("release_valid", inst_valid_o, 0);
        check("release_adel", exc_adel_o, 0);
        check("release_buserr", exc_buserr_o, 0);
        check("release_stallreq", stallreq_o, 0);
    endtask

    // A fetch flushed at cycle flush_at (counted from the IDLE cycle, always
    // before DONE). Nothing may be delivered, a started read must complete,
    // and fetch_en drops so the controller settles in IDLE.
    task automatic run_flushed(input logic [31:0] pc, input logic [31:0] pc_new,
                               input int ar_wait, input int r_wait, input int flush_at);
        int cyc, arw, rw, n_ar, n_r;
        bit quiet, ar_started;
        cyc = 0; arw = 0; rw = 0; n_ar = 0; n_r = 0; quiet = 0; ar_started = 0;
        pc_i = pc; fetch_en_i = 1'b1; stall_i = 6'h0;
        while (!quiet && cyc < 64) begin
            flush_i = (cyc == flush_at);
            if (cyc >= flush_at) begin
                fetch_en_i = 1'b0;
                pc_i       = pc_new;
            end
            arready = arvalid && (arw >= ar_wait);
            rvalid  = rready && (rw >= r_wait);
            rdata   = 32'hDEAD_BEEF;
            rresp   = 2'b00;
            #1;
            check("flush_no_valid", inst_valid_o, 0);
            check("flush_one_channel", arvalid & rready, 0);
            if (arvalid) begin
                check("flush_araddr_stable", araddr, pc);
                if (cyc <= flush_at) ar_started = 1;
                arw++;
                if (arready) n_ar++;
            end
            if (rready) begin
                rw++;
                if (rvalid) n_r++;
            end
            if (cyc > flush_at && !arvalid && !rready && !stallreq_o) begin
                quiet = 1;
            end else begin
                cyc++;
                tick;
            end
        end
        flush_i = 1'b0; arready = 1'b0; rvalid = 1'b0;
        check("flush_settled", quiet, 1);
        check("flush_ar_done", n_ar, ar_started);
        check("flush_r_drained", n_r, n_ar);
    endtask

    task automatic idle_hold(input int n);
        fetch_en_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            pc_i = $urandom;
            #1;
            check("idle_stallreq", stallreq_o, 0);
            check("idle_valid", inst_valid_o, 0);
            check("idle_arvalid", arvalid, 0);
            tick;
        end
    endtask

    initial begin
        logic [31:0] rpc, rword;
        logic [1:0]  rresp_v;
        int          mode;

        rst = 1'b1; pc_i = 32'h0; fetch_en_i = 1'b0; stall_i = 6'h0; flush_i = 1'b0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        @(negedge clk);
        tick; tick;
        check("rst_araddr", araddr, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_inst", inst_o, 0);
        check("rst_valid", inst_valid_o, 0);
        check("rst_adel", exc_adel_o, 0);
        check("rst_buserr", exc_buserr_o, 0);
        rst = 1'b0;

        run_fetch(32'hBFC0_0000, 0, 0, 32'h2408_0001, 2'b00, 0, 0);
        run_fetch(32'hBFC0_0004, 3, 2, 32'h1234_5678, 2'b00, 0, 0);
        run_fetch(32'hBFC0_0002, 0, 0, 32'h0, 2'b00, 1, 0);
        run_fetch(32'hBFC0_0008, 1, 1, 32'hCAFE_F00D, 2'b10, 0, 0);
        run_fetch(32'hBFC0_000C, 0, 0, 32'h0000_0013, 2'b00, 5, 0);
        run_fetch(32'hBFC0_0010, 0, 0, 32'h0C00_0001, 2'b00, 2, 1);

        // Flush in ADDR with arready low, then a dropped DEADBEEF beat
        run_flushed(32'hBFC0_0020, 32'h8000_0180, 3, 0, 1);
        run_fetch(32'h8000_0180, 0, 0, 32'h4210_0018, 2'b00, 0, 0);
        // Flush in DATA coincident with rvalid, and flush in IDLE
        run_flushed(32'hBFC0_0024, 32'h8000_0200, 0, 1, 3);
        run_flushed(32'hBFC0_0028, 32'h8000_0204, 0, 0, 0);

        idle_hold(3);

        // Reset while waiting in the data phase
        pc_i = 32'hBFC0_0030; fetch_en_i = 1'b1;
        tick;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        #1;
        check("pre_rst_rready", rready, 1);
        rst = 1'b1;
        tick;
        check("mid_rst_rready", rready, 0);
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_araddr", araddr, 0);
        check("mid_rst_valid", inst_valid_o, 0);
        rst = 1'b0; fetch_en_i = 1'b0;
        tick;

        for (int k = 0; k < 30; k++) begin
            rpc  = $urandom;
            rword = $urandom;
            mode = $urandom_range(0, 5);
            if ($urandom_range(0, 4) != 0) rpc[1:0] = 2'b00;
            rresp_v = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if (mode == 0) begin
                int aw, rw2;
                aw  = $urandom_range(0, 3);
                rw2 = $urandom_range(0, 3);
                rpc[1:0] = 2'b00;
                run_flushed(rpc, rword & 32'hFFFF_FFFC, aw, rw2,
                            $urandom_range(0, 2 + aw + rw2));
            end else if (mode == 1) begin
                idle_hold($urandom_range(1, 3));
            end else begin
                run_fetch(rpc, $urandom_range(0, 3), $urandom_range(0, 3), rword, rresp_v,
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
